// File: rtl/bidir_bus_xcvr_pkg.sv
// Shared types and helpers for the half-duplex bus transceiver.
// Holds the FSM state encoding and the sizing rule for the shared cycle counter.
package bidir_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    RSETTLE = 3'd2,
    RSAMPLE = 3'd3,
    TURN    = 3'd4
  } state_t;

  // Width needed to hold the largest phase length; never below one bit.
  function automatic int cnt_w(input int hold_cyc, input int turn_cyc, input int settle_cyc);
    int m;
    m = hold_cyc;
    if (turn_cyc > m) m = turn_cyc;
    if (settle_cyc > m) m = settle_cyc;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bus_pad_drv.sv
// Pad-side driver: registered write word and output enable feeding the tri-state bus.
// The enable is a flop so the pad never glitches on combinational FSM decode.
module bus_pad_drv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             oe_i,
  output logic             bus_oe_o,
  inout  wire  [WIDTH-1:0] bus_io
);

  logic [WIDTH-1:0] drv_q;
  logic             bus_oe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drv_q    <= '0;
      bus_oe_q <= 1'b0;
    end else begin
      if (load_i) drv_q <= data_i;
      bus_oe_q <= oe_i;
    end
  end

  assign bus_io   = bus_oe_q ? drv_q : {WIDTH{1'bz}};
  assign bus_oe_o = bus_oe_q;

endmodule

// File: rtl/bidir_bus_xcvr.sv
// Half-duplex controller for one shared tri-state bus: drives writes, samples reads,
// and inserts hold/turnaround gaps so the two ends never drive at the same time.
module bidir_bus_xcvr
  import bidir_bus_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int HOLD_CYC   = 2,
  parameter int TURN_CYC   = 1,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  input  logic             rx_req,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  inout  wire  [WIDTH-1:0] bus_io,
  output logic             bus_oe,
  output logic             busy
);

  localparam int CW = cnt_w(HOLD_CYC, TURN_CYC, SETTLE_CYC);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q, rx_valid_d;
  logic             accept;
  logic             oe_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_valid_q <= rx_valid_d;
      if (state_q == RSAMPLE) rx_data_q <= bus_io;
    end
  end

  // Counter is loaded with (length-1) on entry; a phase ends when it reads zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          accept  = 1'b1;
          state_d = DRIVE;
          cnt_d   = HOLD_LD;
        end else if (rx_req) begin
          state_d = RSETTLE;
          cnt_d   = SETTLE_LD;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = TURN;
          cnt_d   = TURN_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RSETTLE: begin
        if (cnt_q == '0) begin
          state_d = RSAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RSAMPLE: begin
        rx_valid_d = 1'b1;
        state_d    = TURN;
        cnt_d      = TURN_LD;
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    oe_d = (state_d == DRIVE);
  end

  bus_pad_drv #(
    .WIDTH (WIDTH)
  ) u_pad (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .data_i   (tx_data),
    .oe_i     (oe_d),
    .bus_oe_o (bus_oe),
    .bus_io   (bus_io)
  );

  assign tx_ready = accept & ~rst;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bidir_bus_xcvr.sv
// Self-checking bench for bidir_bus_xcvr: timing windows are derived from the phase lengths,
// with a far-end bus model and a contention monitor.
module tb_bidir_bus_xcvr;

  localparam int W      = 8;
  localparam int HOLD   = 2;
  localparam int TURN   = 1;
  localparam int SETTLE = 1;
  localparam int P      = 1 + HOLD + TURN;
  localparam int RLAT   = SETTLE + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         tx_valid;
  logic [W-1:0] tx_data;
  logic         tx_ready;
  logic         rx_req;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  wire  [W-1:0] bus_io;
  logic         bus_oe;
  logic         busy;

  logic         far_oe;
  logic [W-1:0] far_data;

  int n_cmp = 0;
  int n_bad = 0;

  assign bus_io = far_oe ? far_data : {W{1'bz}};

  always #5 clk = ~clk;

  bidir_bus_xcvr #(
    .WIDTH(W), .HOLD_CYC(HOLD), .TURN_CYC(TURN), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_req   (rx_req),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .bus_io   (bus_io),
    .bus_oe   (bus_oe),
    .busy     (busy)
  );

  // Both ends must never drive together.
  always @(negedge clk) begin
    if (far_oe === 1'b1 && bus_oe === 1'b1) begin
      n_bad++;
      $display("FAIL contention: far_oe=%b bus_oe=%b required not both 1", far_oe, bus_oe);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; far_oe = 1'b1; far_data = 8'hFF;
    tx_valid = 1'b1; tx_data = 8'h5A; rx_req = 1'b0;
    repeat (3) tick();
    #1;
    n_cmp++; if (bus_oe !== 1'b0)   begin n_bad++; $display("FAIL reset_oe: got %b want 0", bus_oe); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (bus_io !== 8'hFF)  begin n_bad++; $display("FAIL reset_bus: got %h want ff", bus_io); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    tx_valid = 1'b0; far_oe = 1'b0; rst = 1'b0;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_write(input logic [W-1:0] d);
    tx_data = d; tx_valid = 1'b1;
    #1;
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL wr_accept: got %b want 1", tx_ready); end
    tick();
    tx_valid = 1'b0; tx_data = 8'($urandom);
    for (int k = 1; k <= HOLD + TURN; k++) begin
      #1;
      n_cmp++; if (bus_oe !== (k <= HOLD)) begin n_bad++; $display("FAIL wr_oe k=%0d: got %b want %b", k, bus_oe, (k <= HOLD)); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy k=%0d: got %b want 1", k, busy); end
      n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL wr_ready_repeat k=%0d: got %b want 0", k, tx_ready); end
      if (k <= HOLD) begin
        n_cmp++; if (bus_io !== d) begin n_bad++; $display("FAIL wr_bus k=%0d: got %h want %h", k, bus_io, d); end
      end
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_idle: got busy=%b want 0", busy); end
    $display("txn write data=%h", d);
  endtask

  task automatic test_read(input logic [W-1:0] d);
    far_data = d; far_oe = 1'b1; rx_req = 1'b1;
    #1;
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL rd_no_ready: got %b want 0", tx_ready); end
    tick();
    rx_req = 1'b0;
    for (int k = 1; k <= SETTLE + 1 + TURN; k++) begin
      n_cmp++; if (bus_oe !== 1'b0) begin n_bad++; $display("FAIL rd_oe k=%0d: got %b want 0", k, bus_oe); end
      n_cmp++; if (rx_valid !== (k == RLAT)) begin n_bad++; $display("FAIL rd_valid k=%0d: got %b want %b", k, rx_valid, (k == RLAT)); end
      if (k == RLAT) begin
        n_cmp++; if (rx_data !== d) begin n_bad++; $display("FAIL rd_data: got %h want %h", rx_data, d); end
      end
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_idle: got busy=%b want 0", busy); end
    n_cmp++; if (rx_data !== d) begin n_bad++; $display("FAIL rd_hold: got %h want %h", rx_data, d); end
    far_oe = 1'b0;
    $display("txn read data=%h", d);
  endtask

  task automatic test_collision();
    logic [W-1:0] rd;
    rd = 8'($urandom);
    tx_data = 8'h0F; tx_valid = 1'b1; rx_req = 1'b1; far_oe = 1'b0;
    #1;
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL col_accept: got %b want 1", tx_ready); end
    tick();
    tx_valid = 1'b0;
    for (int k = 1; k <= HOLD + TURN; k++) begin
      n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL col_no_rx k=%0d: got %b want 0", k, rx_valid); end
      n_cmp++; if (bus_oe !== (k <= HOLD)) begin n_bad++; $display("FAIL col_oe k=%0d: got %b want %b", k, bus_oe, (k <= HOLD)); end
      if (k <= HOLD) begin
        n_cmp++; if (bus_io !== 8'h0F) begin n_bad++; $display("FAIL col_bus k=%0d: got %h want 0f", k, bus_io); end
      end
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL col_idle: got busy=%b want 0", busy); end
    far_data = rd; far_oe = 1'b1;
    tick();
    rx_req = 1'b0;
    for (int k = 1; k <= SETTLE + 1 + TURN; k++) begin
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL col_rd_busy k=%0d: got %b want 1", k, busy); end
      n_cmp++; if (rx_valid !== (k == RLAT)) begin n_bad++; $display("FAIL col_rd_valid k=%0d: got %b want %b", k, rx_valid, (k == RLAT)); end
      if (k == RLAT) begin
        n_cmp++; if (rx_data !== rd) begin n_bad++; $display("FAIL col_rd_data: got %h want %h", rx_data, rd); end
      end
      tick();
    end
    far_oe = 1'b0;
    $display("txn collision write=0f then read=%h", rd);
  endtask

  task automatic test_back_to_back();
    int readies;
    logic exp_oe;
    readies = 0;
    tx_data = 8'h01; tx_valid = 1'b1;
    for (int k = 0; k < 2 * P; k++) begin
      if (k == 1) tx_data = 8'h02;
      if (k == P + 1) tx_valid = 1'b0;
      #1;
      exp_oe = ((k % P) >= 1) && ((k % P) <= HOLD);
      if (tx_ready === 1'b1) readies++;
      n_cmp++; if (tx_ready !== ((k % P) == 0)) begin n_bad++; $display("FAIL b2b_ready k=%0d: got %b want %b", k, tx_ready, ((k % P) == 0)); end
      n_cmp++; if (bus_oe !== exp_oe) begin n_bad++; $display("FAIL b2b_oe k=%0d: got %b want %b", k, bus_oe, exp_oe); end
      if (exp_oe) begin
        n_cmp++; if (bus_io !== ((k < P) ? 8'h01 : 8'h02)) begin n_bad++; $display("FAIL b2b_bus k=%0d: got %h want %h", k, bus_io, ((k < P) ? 8'h01 : 8'h02)); end
      end
      tick();
    end
    n_cmp++; if (readies != 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", readies); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
    $display("txn back_to_back writes=01,02 period=%0d", P);
  endtask

  task automatic test_reset_mid_drive();
    logic [W-1:0] d;
    d = 8'($urandom);
    tx_data = d; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n_cmp++; if (bus_oe !== 1'b1) begin n_bad++; $display("FAIL rmd_drive1: got %b want 1", bus_oe); end
    tick();
    n_cmp++; if (bus_oe !== 1'b1) begin n_bad++; $display("FAIL rmd_drive2: got %b want 1", bus_oe); end
    rst = 1'b1;
    tick();
    n_cmp++; if (bus_oe !== 1'b0)   begin n_bad++; $display("FAIL rmd_release: got %b want 0", bus_oe); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL rmd_ready: got %b want 0", tx_ready); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (busy !== 1'b0 || bus_oe !== 1'b0 || tx_ready !== 1'b0) begin
        n_bad++; $display("FAIL rmd_idle k=%0d: got busy=%b oe=%b ready=%b want 0/0/0", k, busy, bus_oe, tx_ready);
      end
    end
    $display("txn reset_mid_drive data=%h", d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    far_oe = 1'b0; far_data = '0; rst = 1'b1;
    tx_valid = 1'b0; tx_data = '0; rx_req = 1'b0;
    test_reset();
    test_write(8'hA5);
    test_read(8'h3C);
    test_collision();
    test_back_to_back();
    test_reset_mid_drive();
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) test_write(8'($urandom));
      else test_read(8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
